uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (range 2..16).
REQ-002 Parameter LOCK_TIMEOUT, default 1024, idle cycles a locked requester may stall before its lock is revoked (at least 2).
REQ-003 Port clk, input, 1, the single clock; every register is clocked on posedge clk.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, NUM_REQ, bit i set means requester i offers a byte.
REQ-006 Port req_data, input, 8*NUM_REQ, requester i byte on bits [8i+7:8i].
REQ-007 Port req_last, input, NUM_REQ, bit i marks the final byte of requester i packet.
REQ-008 Port req_ready, output, NUM_REQ, bit i set means requester i byte is taken this cycle (valid and ready both high).
REQ-009 Port tx_have_new_data, output, 1, drives the transmitter have_new_data.
REQ-010 Port tx_new_data, output, 8, drives the transmitter new_data.
REQ-011 Port tx_ready, input, 1, from the transmitter ready_for_new_data.
REQ-012 Port grant_id, output, $clog2(NUM_REQ), index of the current or most recent grantee.
REQ-013 Port busy, output, 1, high whenever state is not IDLE.
REQ-014 Port lock_abort, output, 1, one-cycle pulse when a lock is revoked by timeout.

Function
REQ-015 The block SHALL implement exactly three states: IDLE, ACCEPT and OFFER.
REQ-016 In IDLE with any req_valid high, the block SHALL grant the first valid index searching upward from (last_grant+1) mod NUM_REQ with wrap-around, load grant_id, and enter ACCEPT next cycle.
REQ-017 In ACCEPT, req_ready SHALL be one-hot at grant_id (combinational from state and grant_id) and zero elsewhere; in every other state req_ready SHALL be all zero.
REQ-018 In ACCEPT with req_valid[grant_id] high, the block SHALL capture req_data and req_last for grant_id into a 9-bit hold register and enter OFFER.
REQ-019 In ACCEPT with req_valid[grant_id] low and no lock held, the block SHALL return to IDLE without updating last_grant.
REQ-020 In OFFER, tx_have_new_data SHALL be 1 and tx_new_data SHALL equal the held byte; in all other states tx_have_new_data SHALL be 0.
REQ-021 In OFFER with tx_ready high, the transfer completes at that edge: if held last=1, the block SHALL clear the lock, set last_grant to grant_id, and enter IDLE; otherwise it SHALL set the lock and enter ACCEPT with the same grant_id.
REQ-022 In OFFER with tx_ready low, the block SHALL remain in OFFER with byte and outputs stable.
REQ-023 While locked, the block SHALL never grant another requester, even when others are valid.
REQ-024 While locked in ACCEPT with req_valid[grant_id] low, a stall counter SHALL increment each cycle and reset to 0 on any acceptance.
REQ-025 When the stall counter reaches LOCK_TIMEOUT-1, the block SHALL clear the lock, set last_grant to grant_id, pulse lock_abort for exactly one cycle, and enter IDLE.
REQ-026 Best-case latency SHALL be: valid seen in IDLE at cycle 0, req_ready at cycle 1, tx_have_new_data at cycle 2.
REQ-027 Simultaneous valid requests SHALL be resolved solely by the round-robin pointer; no requester is granted twice in a row while another is valid and no lock is held.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state IDLE, req_ready 0, tx_have_new_data 0, tx_new_data 0, grant_id 0, busy 0, lock_abort 0, lock cleared, stall counter 0, and last_grant NUM_REQ-1.
REQ-029 Reset during ACCEPT or OFFER SHALL discard the held byte without signalling any requester; a frame already latched by the transmitter is unaffected.
REQ-030 After rst_n deasserts, the first grant SHALL go to the lowest-indexed valid requester.

Verification
REQ-031 Single byte: req_valid=0001, req_data[7:0]=0x55, last=1, tx_ready=1 -> req_ready[0] at cycle 1, tx_new_data=0x55 with have_new_data at cycle 2, IDLE at cycle 3.
REQ-032 Fairness: all four valid continuously with last=1 -> grant order 0,1,2,3,0 and one byte each.
REQ-033 Packet lock: requester 2 sends 3 bytes (last on third) while requester 0 is valid -> all 3 bytes from requester 2 are sent back-to-back, then requester 0 is granted.
REQ-034 Transmitter busy: hold tx_ready low for 50 cycles in OFFER -> have_new_data stays high and the byte stays stable; the byte completes on the first tx_ready high.
REQ-035 Timeout: LOCK_TIMEOUT=8, requester 1 sends a non-last byte and then drops valid -> lock_abort pulses once 8 stall cycles later and the next valid requester is granted.
REQ-036 Reset mid-OFFER: drop rst_n -> all outputs reach reset values with no clock edge; the held byte is never presented afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding a single UART transmitter
// Whole packets from one requester go out back to back; a stalled packet loses its lock after a timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_have_new_data,
    output logic [7:0]                 tx_new_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       lock_abort
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = $clog2(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_OFFER
    } state_t;

    state_t        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_grant_q;
    logic          lock_q;
    logic          lock_abort_q;
    logic [SW-1:0] stall_q;
    logic [8:0]    hold_q;

    logic          rr_found;
    logic [GW-1:0] rr_pick;
    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;

    // First valid requester strictly after the previous grantee, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        sel_valid = req_valid[grant_q];
        sel_last  = req_last[grant_q];
        sel_data  = req_data[int'(grant_q)*8 +: 8];
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_ACCEPT) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign tx_have_new_data = (state_q == ST_OFFER);
    assign tx_new_data      = (state_q == ST_OFFER) ? hold_q[7:0] : 8'h00;
    assign grant_id         = grant_q;
    assign busy             = (state_q != ST_IDLE);
    assign lock_abort       = lock_abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            lock_q       <= 1'b0;
            lock_abort_q <= 1'b0;
            stall_q      <= '0;
            hold_q       <= '0;
        end else begin
            lock_abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_q <= rr_pick;
                        state_q <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (sel_valid) begin
                        hold_q  <= {sel_last, sel_data};
                        stall_q <= '0;
                        state_q <= ST_OFFER;
                    end else if (!lock_q) begin
                        // Requester withdrew before a packet started: keep its turn.
                        state_q <= ST_IDLE;
                    end else if (stall_q == SW'(LOCK_TIMEOUT - 1)) begin
                        lock_q       <= 1'b0;
                        stall_q      <= '0;
                        last_grant_q <= grant_q;
                        lock_abort_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (tx_ready) begin
                        if (hold_q[8]) begin
                            lock_q       <= 1'b0;
                            last_grant_q <= grant_q;
                            state_q      <= ST_IDLE;
                        end else begin
                            lock_q  <= 1'b1;
                            state_q <= ST_ACCEPT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
// Requesters replay byte lists; a monitor checks every completed transmitter byte against the queue.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int LT = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_have_new_data;
    logic [7:0]     tx_new_data;
    logic           tx_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           lock_abort;

    int checks = 0;
    int errors = 0;

    logic [8:0] mem [N][16];
    int         head [N] = '{default: 0};
    int         tail [N] = '{default: 0};
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .tx_have_new_data (tx_have_new_data),
        .tx_new_data      (tx_new_data),
        .tx_ready         (tx_ready),
        .grant_id         (grant_id),
        .busy             (busy),
        .lock_abort       (lock_abort)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load(input int r, input logic last, input logic [7:0] data);
        mem[r][tail[r]] = {last, data};
        tail[r]++;
    endtask

    task automatic expect_byte(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_have(input string name, input bit need_ready);
        bit seen;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (tx_have_new_data && (!need_ready || tx_ready)) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_have"}, tx_have_new_data, 0);
        chk({tag, "_data"}, tx_new_data, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_abort"}, lock_abort, 0);
    endtask

    // Requester models: present the head byte, pop it after a handshake edge.
    initial begin
        logic [N-1:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) head[i]++;
                if (head[i] != tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = mem[i][head[i]][7:0];
                    req_last[i]        = mem[i][head[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: each byte the transmitter takes must be the next expected one.
    initial begin
        logic       prev_have;
        logic       prev_rdy;
        logic [7:0] prev_data;
        logic [9:0] e;
        prev_have = 0;
        prev_rdy  = 0;
        prev_data = 0;
        forever begin
            @(negedge clk);
            if (prev_have && !prev_rdy && tx_have_new_data)
                chk("offer_stable", tx_new_data, prev_data);
            if (tx_have_new_data && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=id%0d/%h required=none", grant_id, tx_new_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {grant_id, tx_new_data}, e);
                end
            end
            prev_have = tx_have_new_data;
            prev_rdy  = tx_ready;
            prev_data = tx_new_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_ready = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Single byte with best-case latency.
        load(0, 1'b1, 8'h55);
        expect_byte(2'd0, 8'h55);
        @(posedge clk); #2;
        @(negedge clk);
        chk("lat_c0_ready", req_ready, 4'b0000);
        chk("lat_c0_busy", busy, 0);
        @(negedge clk);
        chk("lat_c1_ready", req_ready, 4'b0001);
        chk("lat_c1_have", tx_have_new_data, 0);
        @(negedge clk);
        chk("lat_c2_have", tx_have_new_data, 1);
        chk("lat_c2_data", tx_new_data, 8'h55);
        chk("lat_c2_ready", req_ready, 4'b0000);
        @(negedge clk);
        chk("lat_c3_busy", busy, 0);
        drain(50);

        // Fairness from a fresh pointer.
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        load(0, 1'b1, 8'h10); load(0, 1'b1, 8'h11);
        load(1, 1'b1, 8'h21); load(2, 1'b1, 8'h32); load(3, 1'b1, 8'h43);
        expect_byte(2'd0, 8'h10); expect_byte(2'd1, 8'h21); expect_byte(2'd2, 8'h32);
        expect_byte(2'd3, 8'h43); expect_byte(2'd0, 8'h11);
        drain(200);

        // Packet lock: requester 2 keeps the transmitter for its whole packet.
        @(posedge clk); #2;
        load(2, 1'b0, 8'hA0); load(2, 1'b0, 8'hA1); load(2, 1'b1, 8'hA2);
        load(0, 1'b1, 8'hB0);
        expect_byte(2'd2, 8'hA0); expect_byte(2'd2, 8'hA1); expect_byte(2'd2, 8'hA2);
        expect_byte(2'd0, 8'hB0);
        drain(200);

        // Transmitter busy for 50 cycles.
        @(posedge clk); #2;
        tx_ready = 1'b0;
        load(3, 1'b1, 8'hC3);
        expect_byte(2'd3, 8'hC3);
        wait_have("busy_offer_seen", 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("busy_have", tx_have_new_data, 1);
            chk("busy_data", tx_new_data, 8'hC3);
        end
        @(posedge clk); #2;
        tx_ready = 1'b1;
        drain(50);

        // Lock timeout: requester 1 stalls mid-packet while requester 2 waits.
        @(posedge clk); #2;
        load(1, 1'b0, 8'hD1);
        load(2, 1'b1, 8'hE2);
        expect_byte(2'd1, 8'hD1);
        expect_byte(2'd2, 8'hE2);
        wait_have("to_first_byte", 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_stall_abort", lock_abort, 0);
            chk("to_stall_ready", req_ready, 4'b0010);
        end
        @(negedge clk);
        chk("to_abort_pulse", lock_abort, 1);
        chk("to_abort_busy", busy, 0);
        @(negedge clk);
        chk("to_abort_end", lock_abort, 0);
        chk("to_next_grant", req_ready, 4'b0100);
        drain(50);

        // Reset while a byte is being offered.
        @(posedge clk); #2;
        tx_ready = 1'b0;
        load(0, 1'b1, 8'hF0);
        wait_have("mid_offer_seen", 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #2;
        tx_ready = 1'b1;
        rst_n    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", tx_have_new_data, 0);
        end

        // First grant after reset goes to the lowest valid index.
        @(posedge clk); #2;
        load(2, 1'b1, 8'h92);
        load(1, 1'b1, 8'h91);
        expect_byte(2'd1, 8'h91);
        expect_byte(2'd2, 8'h92);
        drain(50);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
